md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result-register width.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  1  0 = MULTU (unsigned multiply), 1 = DIVU (unsigned divide).
- A  in  WIDTH  multiplicand or dividend, from EX operand A.
- B  in  WIDTH  multiplier or divisor, from EX operand B.
- flush  in  1  abort the in-flight operation (branch squash).
- stall  out  1  freezes the IF/ID/EX pipeline registers.
- busy  out  1  sequencer not in IDLE.
- done  out  1  one-cycle pulse when HI/LO update.
- div_by_zero  out  1  sticky flag for the last DIVU with B = 0.
- HI  out  WIDTH  upper product or remainder.
- LO  out  WIDTH  lower product or quotient.

Function
REQ-003 The block SHALL implement the FSM states IDLE, RUN and DONE, with a cycle counter of clog2(WIDTH)+1 bits.
REQ-004 In IDLE, start=1 SHALL latch A, B and op, clear the counter and the partial registers, and transition to RUN on the next edge.
REQ-005 start SHALL be ignored in RUN and DONE; it is not queued.
REQ-006 RUN SHALL process exactly one operand bit per cycle for WIDTH cycles, then transition to DONE.
- MULTU: shift-add into a 2*WIDTH-bit accumulator.
- DIVU: restoring shift-subtract; remainder is WIDTH+1 bits wide.
REQ-007 In DONE, HI and LO SHALL be written and done SHALL equal 1 for exactly that cycle; the next state is IDLE.
REQ-008 Latency: for start accepted at edge t, done SHALL be high in cycle t+WIDTH+1, which is cycle 33 for WIDTH = 32.
REQ-009 MULTU results: {HI,LO} = A*B as an unsigned 2*WIDTH-bit product, with no overflow.
REQ-010 DIVU results: LO = floor(A/B) and HI = A mod B, both unsigned.
REQ-011 DIVU with B=0 SHALL skip RUN and go IDLE->DONE. In DONE:
- LO = all ones and HI = A.
- div_by_zero = 1; the cycle after start is the done cycle.
REQ-012 div_by_zero SHALL be cleared when the next operation is accepted, unless that operation is itself a divide by zero.
REQ-013 stall SHALL be combinational:
- high when (IDLE and start), and high throughout RUN;
- low in DONE, so the pipeline advances in the done cycle.
REQ-014 busy SHALL be high in RUN and DONE.
REQ-015 flush SHALL have priority over the FSM in RUN or DONE: next state is IDLE, HI/LO are not written, done stays 0, and div_by_zero is unchanged.
REQ-016 flush in IDLE SHALL block acceptance of start in that same cycle.
REQ-017 HI and LO SHALL hold their value between operations; they are readable (for MFHI/MFLO) at all times.

Reset
REQ-018 Asserting reset low SHALL immediately, without waiting for a clock edge, set:
- state = IDLE and counter = 0;
- HI = 0, LO = 0;
- done = 0, busy = 0, div_by_zero = 0, all partial registers = 0.
REQ-019 While reset is low, stall SHALL be 0 and start SHALL be ignored.
REQ-020 Reset asserted mid-RUN SHALL discard the operation; after release the block SHALL accept a new start normally.

Verification
REQ-021 MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> done in cycle 33, HI=0xFFFFFFFE, LO=0x00000001, stall high for cycles 0-32.
REQ-022 DIVU with A=100, B=7 -> done in cycle 33, LO=14, HI=2, div_by_zero=0.
REQ-023 DIVU with A=0x12345678, B=0 -> done in cycle 1, LO=0xFFFFFFFF, HI=0x12345678, div_by_zero=1. A following MULTU 3*5 clears the flag and gives HI=0, LO=15.
REQ-024 start pulsed every cycle during a MULTU 6*7 -> exactly one done, {HI,LO}=42; the second operation starts only from IDLE.
REQ-025 flush in RUN at counter=5 -> IDLE next cycle, no done pulse, and HI/LO retain the prior result.
REQ-026 reset driven low in RUN at counter=10 -> all outputs 0 at once. After release, DIVU 9/3 gives LO=3, HI=0 in cycle 33.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer bus: operation request in, status and HI/LO results out.
// Latency: none, this is wiring only.
// Backpressure: the sequencer raises stall to freeze the issuing pipeline; no other flow control.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  // Pipeline side: issues operations and reads the architectural HI/LO.
  modport master (
    output start, op, A, B, flush,
    input  stall, busy, done, div_by_zero, HI, LO
  );

  // Sequencer side.
  modport slave (
    input  start, op, A, B, flush,
    output stall, busy, done, div_by_zero, HI, LO
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative MULTU/DIVU unit: one operand bit per cycle, results land in HI/LO.
// Latency: done WIDTH+1 cycles after the start cycle (1 cycle for a divide by zero).
// Backpressure: stall holds the pipeline from the start cycle through the last RUN cycle.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  md_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  // MULTU: {upper partial product, multiplier bits still to consume}.
  // DIVU: low half holds dividend bits shifting out and quotient bits shifting in.
  logic [2*WIDTH-1:0] acc;
  // Restored remainder; the working remainder is the WIDTH+1 bit value 'shifted'.
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic               accept;
  logic               b_zero;
  logic               last;
  logic [WIDTH:0]     madd;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               ge;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Flush in IDLE wins over start in the same cycle.
  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign b_zero = (bus.B == '0);
  assign last   = (cnt == CW'(WIDTH - 1));

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

  // One restoring step: bring in the next dividend bit and try to subtract the divisor.
  // shifted < 2*B, so a non-negative trial always fits back into WIDTH bits.
  assign shifted = {rem, acc[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, b_q};
  assign ge      = (trial[WIDTH+1:WIDTH] == 2'b00);

  // Select the result to publish in the DONE cycle.
  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (op_q) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = acc[WIDTH-1:0];
      end
    end
  end

  // Sequencer FSM with the datapath and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      rem   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= bus.op;
            cnt   <= '0;
            rem   <= '0;
            dbz_q <= bus.op && b_zero;
            acc   <= {{WIDTH{1'b0}}, (bus.op ? bus.A : bus.B)};
            state <= (bus.op && b_zero) ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (op_q) begin
              rem              <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
              acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ge};
            end else begin
              acc <= {madd, acc[WIDTH-1:1]};
            end
            if (last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (!bus.flush) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // done and HI/LO are decoded from the DONE state so a flush arriving in that very
  // cycle can still suppress the pulse and the register write.
  assign bus.done        = (state == DONE) && !bus.flush;
  assign bus.HI          = bus.done ? res_hi : hi_q;
  assign bus.LO          = bus.done ? res_lo : lo_q;
  assign bus.busy        = (state != IDLE);
  assign bus.div_by_zero = dbz_q;
  assign bus.stall       = reset && (((state == IDLE) && bus.start) || (state == RUN));

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed cases with literal results plus randomized traffic.
// Latency: outputs compared against a cycle-level operation model every cycle.
// Backpressure: stall, busy and done are all part of the per-cycle comparison.
module tb_md_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_sequencer_if #(.WIDTH(W)) ifc ();

  md_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation-level model: an accepted operation finishes a fixed number of cycles later.
  bit               m_busy = 1'b0;
  int               m_t = 0;
  int               m_lat = 0;
  bit               m_dbz = 1'b0;
  logic [W-1:0]     m_hi = '0;
  logic [W-1:0]     m_lo = '0;
  logic [W-1:0]     p_hi = '0;
  logic [W-1:0]     p_lo = '0;
  logic [2*W-1:0]   prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_dbz  = 1'b0;
    end else if (!m_busy) begin
      if (ifc.start && !ifc.flush) begin
        m_busy = 1'b1;
        m_t    = 1;
        m_lat  = W + 1;
        m_dbz  = 1'b0;
        if (ifc.op) begin
          if (ifc.B == 0) begin
            m_lat = 1;
            m_dbz = 1'b1;
            p_hi  = ifc.A;
            p_lo  = '1;
          end else begin
            p_lo = ifc.A / ifc.B;
            p_hi = ifc.A % ifc.B;
          end
        end else begin
          prod = {{W{1'b0}}, ifc.A} * {{W{1'b0}}, ifc.B};
          p_hi = prod[2*W-1:W];
          p_lo = prod[W-1:0];
        end
      end
    end else if (ifc.flush) begin
      m_busy = 1'b0;
    end else if (m_t == m_lat) begin
      m_hi   = p_hi;
      m_lo   = p_lo;
      m_busy = 1'b0;
    end else begin
      m_t++;
    end
  end

  // Per-cycle comparison on the falling edge, inputs are stable by then.
  logic         e_done, e_stall;
  logic [W-1:0] e_hi, e_lo;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_done  = m_busy && (m_t == m_lat) && !ifc.flush;
      e_stall = reset && (m_busy ? (m_t != m_lat) : ifc.start);
      e_hi    = e_done ? p_hi : m_hi;
      e_lo    = e_done ? p_lo : m_lo;
      chk("ctl{busy,done,stall,dbz}",
          {ifc.busy, ifc.done, ifc.stall, ifc.div_by_zero},
          {m_busy, e_done, e_stall, m_dbz});
      chk("hilo", {ifc.HI, ifc.LO}, {e_hi, e_lo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and measure the done cycle (start cycle = 0) and stall cycles.
  task automatic run_op(input bit o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int scnt, output bit ok);
    ifc.start = 1'b1;
    ifc.op    = o;
    ifc.A     = a;
    ifc.B     = b;
    lat  = 0;
    scnt = 0;
    ok   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.stall) scnt++;
      if (ifc.done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
      tick();
      ifc.start = 1'b0;
    end
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ifc.busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1'b1);
    tick();
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", fails);
    $fatal(1, "time limit");
  end

  initial begin
    int lat, scnt, dcnt;
    bit ok;
    logic [W-1:0] hi_cap, lo_cap;

    ifc.start = 1'b0;
    ifc.op    = 1'b0;
    ifc.A     = '0;
    ifc.B     = '0;
    ifc.flush = 1'b0;

    // Held in reset: everything zero, start ignored and stall low.
    tick();
    ifc.start = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_stall", ifc.stall, 1'b0);
    chk("rst_done_dbz", {ifc.done, ifc.div_by_zero}, 2'b00);
    chk("rst_hilo", {ifc.HI, ifc.LO}, '0);
    tick();
    ifc.start = 1'b0;
    reset = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Largest product.
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, scnt, ok);
    chk("mul_max_seen", ok, 1'b1);
    chk("mul_max_lat", lat, 33);
    chk("mul_max_stall_cycles", scnt, 33);
    chk("mul_max_hi", ifc.HI, 32'hFFFF_FFFE);
    chk("mul_max_lo", ifc.LO, 32'h0000_0001);

    // Ordinary divide.
    run_op(1'b1, 32'd100, 32'd7, lat, scnt, ok);
    chk("div_100_7_lat", lat, 33);
    chk("div_100_7_lo", ifc.LO, 32'd14);
    chk("div_100_7_hi", ifc.HI, 32'd2);
    chk("div_100_7_dbz", ifc.div_by_zero, 1'b0);

    // Divide by zero shortcut, then a multiply clears the flag.
    run_op(1'b1, 32'h1234_5678, 32'd0, lat, scnt, ok);
    chk("dbz_lat", lat, 1);
    chk("dbz_stall_cycles", scnt, 1);
    chk("dbz_lo", ifc.LO, 32'hFFFF_FFFF);
    chk("dbz_hi", ifc.HI, 32'h1234_5678);
    chk("dbz_flag", ifc.div_by_zero, 1'b1);
    run_op(1'b0, 32'd3, 32'd5, lat, scnt, ok);
    chk("mul_3_5_lat", lat, 33);
    chk("mul_3_5_flag", ifc.div_by_zero, 1'b0);
    chk("mul_3_5_hilo", {ifc.HI, ifc.LO}, 64'd15);

    // start held high across a whole multiply: one done, restart only from IDLE.
    ifc.start = 1'b1;
    ifc.op    = 1'b0;
    ifc.A     = 32'd6;
    ifc.B     = 32'd7;
    dcnt   = 0;
    hi_cap = '0;
    lo_cap = '0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (ifc.done) dcnt++;
      if (i == 33) begin
        hi_cap = ifc.HI;
        lo_cap = ifc.LO;
      end
      tick();
    end
    chk("start_held_done_count", dcnt, 1);
    chk("start_held_result", {hi_cap, lo_cap}, 64'd42);
    @(negedge clk);
    chk("start_held_idle_after_done", ifc.busy, 1'b0);
    tick();
    ifc.start = 1'b0;
    wait_idle("start_held_second_op_finishes");

    // Flush while the counter is at 5: back to IDLE, result untouched.
    ifc.start = 1'b1;
    ifc.A     = 32'd1234;
    ifc.B     = 32'd5678;
    tick();
    ifc.start = 1'b0;
    repeat (5) tick();
    ifc.flush = 1'b1;
    @(negedge clk);
    chk("flush_no_done", ifc.done, 1'b0);
    tick();
    ifc.flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", ifc.busy, 1'b0);
    chk("flush_hilo_kept", {ifc.HI, ifc.LO}, 64'd42);
    tick();

    // Reset mid-RUN at counter 10: outputs clear with no clock edge.
    ifc.start = 1'b1;
    ifc.op    = 1'b1;
    ifc.A     = 32'd1000;
    ifc.B     = 32'd3;
    tick();
    ifc.start = 1'b0;
    repeat (10) tick();
    chk("pre_reset_busy", ifc.busy, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_ctl", {ifc.busy, ifc.done, ifc.stall, ifc.div_by_zero}, 4'b0000);
    chk("async_rst_hilo", {ifc.HI, ifc.LO}, '0);
    tick();
    reset = 1'b1;
    tick();
    run_op(1'b1, 32'd9, 32'd3, lat, scnt, ok);
    chk("div_9_3_lat", lat, 33);
    chk("div_9_3_hilo", {ifc.HI, ifc.LO}, 64'd3);

    // Randomized traffic: back-to-back starts, flushes anywhere, varied operands.
    for (int c = 0; c < 4000; c++) begin
      int r;
      ifc.start = ($urandom_range(0, 2) == 0);
      ifc.op    = $urandom_range(0, 1);
      ifc.A     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      r = $urandom_range(0, 7);
      if (r == 0)      ifc.B = '0;
      else if (r < 3)  ifc.B = 32'($urandom_range(1, 20));
      else             ifc.B = $urandom;
      ifc.flush = ($urandom_range(0, 59) == 0);
      tick();
    end
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    wait_idle("random_drain");
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
